// File: rtl/addsub_rr_arbiter.sv
// Two-requester round-robin front end for a shared WIDTH-bit add/subtract datapath with a single-entry result slot.
// Optional signed-overflow output res_ovf is built when ADDSUB_OVF_EN is defined.
module addsub_rr_arbiter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_m,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_m,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id,
    input  logic             res_ready
`ifdef ADDSUB_OVF_EN
    ,
    output logic             res_ovf
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_bx;
    logic             op_m;
    logic [WIDTH:0]   add_full;
`ifdef ADDSUB_OVF_EN
    logic             ovf;
`endif

    // Contention goes to whichever requester was not granted last.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant);
        grant1 = req1_valid & (~req0_valid | ~last_grant);
    end

    always_comb begin
        can_accept = rst_n & ((state == EMPTY) | res_ready);
        req0_ready = can_accept & grant0;
        req1_ready = can_accept & grant1;
        accept     = req0_ready | req1_ready;
    end

    always_comb begin
        op_a     = grant1 ? req1_a : req0_a;
        op_m     = grant1 ? req1_m : req0_m;
        op_bx    = (grant1 ? req1_b : req0_b) ^ {WIDTH{op_m}};
        add_full = {1'b0, op_a} + {1'b0, op_bx} + {{WIDTH{1'b0}}, op_m};
`ifdef ADDSUB_OVF_EN
        // Carry into the MSB is recovered from the MSB sum bit and its operands.
        ovf      = (add_full[WIDTH-1] ^ op_a[WIDTH-1] ^ op_bx[WIDTH-1]) ^ add_full[WIDTH];
`endif
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = FULL;
        end else if ((state == FULL) && res_ready) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_sum    <= '0;
            res_cout   <= 1'b0;
            res_id     <= 1'b0;
            last_grant <= 1'b1;
`ifdef ADDSUB_OVF_EN
            res_ovf    <= 1'b0;
`endif
        end else if (accept) begin
            res_sum    <= add_full[WIDTH-1:0];
            res_cout   <= add_full[WIDTH];
            res_id     <= grant1;
            last_grant <= grant1;
`ifdef ADDSUB_OVF_EN
            res_ovf    <= ovf;
`endif
        end
    end

    assign res_valid = (state == FULL);

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Self-checking bench for addsub_rr_arbiter: per-cycle reference model plus directed literal checks.
module tb_addsub_rr_arbiter;

    localparam int W = 4;
    localparam int M = 1 << W;
    localparam int H = M / 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_m, req0_ready;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_m, req1_ready;
    logic [W-1:0] req1_a, req1_b;
    logic         res_valid, res_cout, res_id, res_ready;
    logic [W-1:0] res_sum;
`ifdef ADDSUB_OVF_EN
    logic         res_ovf;
`endif

    int checks   = 0;
    int failures = 0;

    addsub_rr_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_m     (req0_m),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_m     (req1_m),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id),
        .res_ready  (res_ready)
`ifdef ADDSUB_OVF_EN
        ,
        .res_ovf    (res_ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic on plain integers: unsigned wrap, borrow, signed range.
    task automatic calc(input int a, input int b, input bit m,
                        output int sum, output bit cout, output bit ovf);
        int sa, sb, r;
        if (m) begin
            sum  = (a - b + M) % M;
            cout = (a >= b);
        end else begin
            sum  = (a + b) % M;
            cout = ((a + b) >= M);
        end
        sa  = (a >= H) ? a - M : a;
        sb  = (b >= H) ? b - M : b;
        r   = m ? sa - sb : sa + sb;
        ovf = (r > H - 1) || (r < -H);
    endtask

    bit model_ok = 0;
    bit m_valid, m_cout, m_id, m_last, m_ovf;
    int m_sum;

    initial begin : compare
        bit e0, e1, can, win1, c, o;
        int s;
        forever begin
            @(negedge clk);
            e0 = 0; e1 = 0;
            if (rst_n === 1'b1 && model_ok) begin
                can = !m_valid || res_ready;
                if (req0_valid && req1_valid) win1 = (m_last == 0);
                else                          win1 = req1_valid;
                e0 = can && req0_valid && !win1;
                e1 = can && req1_valid && win1;
            end
            if (rst_n === 1'b0 || model_ok) begin
                chk("model_req0_ready", 32'(req0_ready), 32'(e0));
                chk("model_req1_ready", 32'(req1_ready), 32'(e1));
            end
            if (model_ok) begin
                chk("model_res_valid", 32'(res_valid), 32'(m_valid));
                chk("model_res_sum", 32'(res_sum), 32'(m_sum));
                chk("model_res_cout", 32'(res_cout), 32'(m_cout));
                chk("model_res_id", 32'(res_id), 32'(m_id));
`ifdef ADDSUB_OVF_EN
                chk("model_res_ovf", 32'(res_ovf), 32'(m_ovf));
`endif
            end
            @(posedge clk);
            if (rst_n === 1'b0) begin
                model_ok = 1;
                m_valid = 0; m_sum = 0; m_cout = 0; m_id = 0; m_last = 1; m_ovf = 0;
            end else if (e0 || e1) begin
                if (e1) calc(int'(req1_a), int'(req1_b), req1_m, s, c, o);
                else    calc(int'(req0_a), int'(req0_b), req0_m, s, c, o);
                m_valid = 1; m_sum = s; m_cout = c; m_ovf = o;
                m_id = e1; m_last = e1;
            end else if (m_valid && res_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string name, input bit v, input int sum, input bit cout, input bit id);
        chk({name, "_valid"}, 32'(res_valid), 32'(v));
        chk({name, "_sum"}, 32'(res_sum), 32'(sum));
        chk({name, "_cout"}, 32'(res_cout), 32'(cout));
        chk({name, "_id"}, 32'(res_id), 32'(id));
    endtask

    task automatic set0(input bit v, input int a, input int b, input bit m);
        req0_valid = v; req0_a = W'(a); req0_b = W'(b); req0_m = m;
    endtask

    task automatic set1(input bit v, input int a, input int b, input bit m);
        req1_valid = v; req1_a = W'(a); req1_b = W'(b); req1_m = m;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int ids[4];
        int sums[4];
        ids  = '{0, 1, 0, 1};
        sums = '{2, 4, 2, 4};
        rst_n = 0; res_ready = 1;
        set0(1, 5, 3, 0); set1(0, 0, 0, 0);
        step(); step();
        chk("rst_req0_ready", 32'(req0_ready), 0);
        chk_res("rst", 0, 0, 0, 0);

        rst_n = 1; #1;
        chk("add_req0_ready", 32'(req0_ready), 1);
        chk("add_req1_ready", 32'(req1_ready), 0);
        step();
        chk_res("add", 1, 8, 0, 0);
        set0(0, 0, 0, 0);
        set1(1, 5, 3, 1); #1;
        chk("sub_req1_ready", 32'(req1_ready), 1);
        step();
        chk_res("sub", 1, 2, 1, 1);
        set1(1, 3, 5, 1);
        step();
        chk_res("sub_borrow", 1, 14, 0, 1);
        set1(0, 0, 0, 0);
        step();
        chk_res("drain", 0, 14, 0, 1);

        set0(1, 1, 1, 0); set1(1, 6, 2, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_res($sformatf("rr%0d", i), 1, sums[i], (i % 2 == 1), ids[i][0]);
        end
        set1(0, 0, 0, 0);
        set0(1, 4, 5, 0);
        step();
        chk_res("bp_fill", 1, 9, 0, 0);
        set0(1, 1, 2, 0); res_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_req0_ready%0d", i), 32'(req0_ready), 0);
            step();
            chk_res($sformatf("bp_hold%0d", i), 1, 9, 0, 0);
        end
        res_ready = 1; #1;
        chk("bp_release_ready", 32'(req0_ready), 1);
        step();
        chk_res("bp_next", 1, 3, 0, 0);

        set0(0, 0, 0, 0); set1(1, 2, 2, 0); res_ready = 0; #1;
        chk("mid_full_req1_ready", 32'(req1_ready), 0);
        rst_n = 0; #1;
        chk("mid_rst_req0_ready", 32'(req0_ready), 0);
        chk("mid_rst_req1_ready", 32'(req1_ready), 0);
        step();
        chk_res("mid_rst", 0, 0, 0, 0);
        rst_n = 1; res_ready = 1; set0(1, 1, 0, 0); #1;
        chk("post_rst_req0_ready", 32'(req0_ready), 1);
        chk("post_rst_req1_ready", 32'(req1_ready), 0);
        step();
        chk_res("post_rst", 1, 1, 0, 0);
        set1(0, 0, 0, 0);

        set0(1, 7, 1, 0); step();
        chk_res("ovf_add", 1, 8, 0, 0);
`ifdef ADDSUB_OVF_EN
        chk("ovf_add_ovf", 32'(res_ovf), 1);
`endif
        set0(1, 8, 1, 1); step();
        chk_res("ovf_sub", 1, 7, 1, 0);
`ifdef ADDSUB_OVF_EN
        chk("ovf_sub_ovf", 32'(res_ovf), 1);
`endif
        set0(1, 2, 1, 1); step();
        chk_res("noovf_sub", 1, 1, 1, 0);
`ifdef ADDSUB_OVF_EN
        chk("noovf_sub_ovf", 32'(res_ovf), 0);
`endif
        set0(1, 15, 1, 0); step();
        chk_res("wrap_add", 1, 0, 1, 0);
        set0(1, 0, 0, 1); step();
        chk_res("zero_sub", 1, 0, 1, 0);
        set0(0, 0, 0, 0);
        step(); step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addsub_rr_arbiter.md
Name: addsub_rr_arbiter

Overview:
Shares one WIDTH-bit ripple add/subtract datapath between two requesters. Each requester uses a valid/ready handshake, and grants alternate round-robin. Accepted operations are computed in one cycle and held in a single-entry result register, which a consumer drains through its own valid/ready handshake. The block sits between two operand sources, for example two ALU issue slots, and the shared adder/subtractor.

Parameters:
WIDTH, 4, operand and result width in bits (minimum 2)

Ports:
clk  input  1  rising-edge clock; the only clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
req0_valid  input  1  requester 0 has an operation pending
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req0_m  input  1  requester 0 mode: 0 = A+B, 1 = A-B
req0_ready  output  1  requester 0 operation accepted this cycle
req1_valid, req1_a, req1_b, req1_m, req1_ready  same as requester 0, for requester 1
res_valid  output  1  result register holds a valid result
res_sum  output  WIDTH  A+B or A+~B+1, mod 2^WIDTH
res_cout  output  1  carry out of the MSB; when subtracting, 1 = no borrow (A>=B unsigned)
res_id  output  1  requester index that produced the result
res_ready  input  1  consumer accepts the result

Behaviour:
- Reset: rst_n=0 at a rising edge clears all registers.
  - res_valid=0, res_sum=0, res_cout=0, res_id=0, last_grant=1 (so requester 0 wins first).
  - While rst_n=0, req0_ready=0 and req1_ready=0, combinationally.
  - Reset mid-operation drops any held result with no output.
- Slot state machine: EMPTY (res_valid=0) and FULL (res_valid=1).
  - can_accept = rst_n & (EMPTY | (FULL & res_ready)).
- Arbitration is combinational from the valids and last_grant.
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - reqN_ready = can_accept & grantN. At most one ready is high per cycle.
  - A requester that is valid and not ready keeps its operands stable until accepted.
- Accept: on reqN_valid & reqN_ready at edge N, the following are registered:
  - res_sum/res_cout = A + (B XOR {WIDTH{m}}) + m
  - res_id = N, last_grant = N
  - the slot becomes FULL
  - Latency is 1 cycle: the result is visible after edge N.
- Drain: on res_valid & res_ready with no new accept, the slot goes EMPTY. The result outputs keep their last values; only res_valid drops.
- Drain and accept at the same edge: the slot stays FULL with the new result, so a requester can be accepted every cycle with no bubbles.
- res_ready=0 while FULL: all result outputs hold, and both readies stay 0.
- last_grant changes only on accept. Idle cycles do not alter priority.
- Arithmetic: the carry chain is exactly WIDTH bits. Overflow wraps with no saturation. The carry-in equals m.
- No combinational path from res_ready to res_* outputs. The only path from res_ready to reqN_ready is through can_accept.

Optional Feature:
ADDSUB_OVF_EN
- Defined: adds output port res_ovf (1 bit), the signed two's-complement overflow.
  - Computed as carry-into-MSB XOR carry-out-of-MSB.
  - Registered with res_sum, reset value 0, held under backpressure.
- Undefined: the res_ovf port does not exist and no overflow logic is built. All other behaviour is identical.

Test Plan:
- Add: reset, then req0 valid a=5 b=3 m=0, res_ready=1 -> req0_ready=1 same cycle; next cycle res_valid=1, res_sum=8, res_cout=0, res_id=0.
- Subtract: req1 a=5 b=3 m=1 -> res_sum=2, res_cout=1, res_id=1. Then req1 a=3 b=5 m=1 -> res_sum=14, res_cout=0.
- Contention: both valid continuously for 4 accepts, res_ready=1 -> res_id sequence 0,1,0,1, one result per cycle, no bubbles.
- Backpressure: slot FULL with 9 (4+5), res_ready=0 for 3 cycles with req0 valid -> req0_ready=0 and res_sum=9 stable. Raise res_ready -> req0 accepted the same cycle, and its result appears next.
- Reset mid-op: slot FULL, req1 valid, assert rst_n=0 for one edge -> res_valid=0, res_sum=0, both readies 0. After release, both valid -> req0 granted first.
- ADDSUB_OVF_EN: a=7 b=1 m=0 -> res_sum=8, res_ovf=1. a=8 b=1 m=1 -> res_sum=7, res_ovf=1. a=2 b=1 m=1 -> res_ovf=0.
